// File: rtl/ysyx_22050550_scoreboard_cnt_pkg.sv
// Shared defaults for the counting register scoreboard.
// The FAST build turns on writeback bypass so that a freeing writeback
// releases a dependent instruction in the same cycle.
package ysyx_22050550_scoreboard_cnt_pkg;

  localparam int SB_NR_REGS = 32;
  localparam int SB_AW      = 5;
  localparam int SB_CNT_W   = 2;
  localparam int SB_NUM_WB  = 2;
`ifdef YSYX_22050550_FAST
  localparam int SB_WB_BYPASS = 1;
`else
  localparam int SB_WB_BYPASS = 0;
`endif

  // Width needed to hold a per-register writeback count of 0..num_wb.
  function automatic int sb_dec_width(input int num_wb);
    return (num_wb < 1) ? 1 : $clog2(num_wb + 1);
  endfunction

endpackage

// File: rtl/ysyx_22050550_sb_entry.sv
// One pending-write counter of the scoreboard.
// Ports:
//   clock, reset : rising-edge clock, async active-high reset
//   inc          : one issue targets this register (already gated by ready)
//   dec          : number of writebacks hitting this register this cycle
//   flush        : clear the counter, ignoring inc/dec
//   cnt          : current count
//   nz / sat     : count nonzero / count at its maximum
//   underflow    : this cycle's update would go below zero (clamped to 0)
module ysyx_22050550_sb_entry #(
  parameter int CNT_W = 2,
  parameter int DEC_W = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             inc,
  input  logic [DEC_W-1:0] dec,
  input  logic             flush,
  output logic [CNT_W-1:0] cnt,
  output logic             nz,
  output logic             sat,
  output logic             underflow
);

  // One extra bit beyond the magnitude so a negative result shows up in the MSB.
  localparam int SW = CNT_W + DEC_W + 1;

  logic [SW-1:0]    sum;
  logic [CNT_W-1:0] cnt_next;

  always_comb begin
    sum       = SW'(cnt) + SW'(inc) - SW'(dec);
    underflow = !flush && sum[SW-1];
    cnt_next  = sum[CNT_W-1:0];
    if (flush || sum[SW-1]) begin
      cnt_next = '0;
    end else if (sum[SW-2:CNT_W] != '0) begin
      // Unreachable while issue is gated by ready; hold at max defensively.
      cnt_next = '1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else begin
      cnt <= cnt_next;
    end
  end

  assign nz  = |cnt;
  assign sat = &cnt;

endmodule

// File: rtl/ysyx_22050550_scoreboard_cnt.sv
// Counting register scoreboard: tracks outstanding writes per architectural
// register so several writes to one register may be in flight at once.
// Ports:
//   clock, reset           : rising-edge clock, async active-high reset
//   io_IDU_valid/fire/wen  : issue qualifiers from IDU
//   io_IDU_raddr1/2, waddr : source and destination register addresses
//   io_IDU_busy1/2         : source has pending writes (gated by valid)
//   io_IDU_ready           : destination counter can take another issue
//   io_WB_wen/waddr        : NUM_WB writeback ports, port k at [k*AW +: AW]
//   io_flush               : squash every tracked write
//   io_busy_any            : any register still pending (registered state only)
//   io_err                 : sticky underflow / illegal-issue flag
// Handshake: an issue is taken when io_IDU_valid & io_IDU_fire & io_IDU_wen
// with io_IDU_ready high; firing with ready low drops the issue and sets io_err.
module ysyx_22050550_scoreboard_cnt
  import ysyx_22050550_scoreboard_cnt_pkg::*;
#(
  parameter int NR_REGS   = SB_NR_REGS,
  parameter int AW        = SB_AW,
  parameter int CNT_W     = SB_CNT_W,
  parameter int NUM_WB    = SB_NUM_WB,
  parameter int WB_BYPASS = SB_WB_BYPASS
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 io_IDU_valid,
  input  logic [AW-1:0]        io_IDU_raddr1,
  input  logic [AW-1:0]        io_IDU_raddr2,
  input  logic [AW-1:0]        io_IDU_waddr,
  input  logic                 io_IDU_wen,
  input  logic                 io_IDU_fire,
  output logic                 io_IDU_busy1,
  output logic                 io_IDU_busy2,
  output logic                 io_IDU_ready,
  input  logic [NUM_WB-1:0]    io_WB_wen,
  input  logic [NUM_WB*AW-1:0] io_WB_waddr,
  input  logic                 io_flush,
  output logic                 io_busy_any,
  output logic                 io_err
);

  localparam int DEC_W = sb_dec_width(NUM_WB);

  logic [CNT_W-1:0]   cnt_arr [1:NR_REGS-1];
  logic [DEC_W-1:0]   dec_arr [1:NR_REGS-1];
  logic [NR_REGS-1:1] inc_vec;
  logic [NR_REGS-1:1] nz_vec;
  logic [NR_REGS-1:1] sat_vec;
  logic [NR_REGS-1:1] uf_vec;

  logic issue_ok;
  logic issue_illegal;
  logic wsat;
  logic err_q;

  // Writeback popcount per register.
  always_comb begin
    for (int i = 1; i < NR_REGS; i++) begin
      dec_arr[i] = '0;
      for (int k = 0; k < NUM_WB; k++) begin
        if (io_WB_wen[k] && (io_WB_waddr[k*AW +: AW] == AW'(i))) begin
          dec_arr[i] = dec_arr[i] + DEC_W'(1);
        end
      end
    end
  end

  // Destination saturation lookup; x0 and out-of-range never saturate.
  always_comb begin
    wsat = 1'b0;
    if ((io_IDU_waddr != '0) && (int'(io_IDU_waddr) < NR_REGS)) begin
      wsat = sat_vec[io_IDU_waddr];
    end
  end

  assign io_IDU_ready  = !(io_IDU_wen && wsat);
  assign issue_ok      = io_IDU_valid && io_IDU_fire && io_IDU_wen && io_IDU_ready;
  assign issue_illegal = io_IDU_valid && io_IDU_fire && !io_IDU_ready && !io_flush;

  always_comb begin
    for (int i = 1; i < NR_REGS; i++) begin
      inc_vec[i] = issue_ok && (io_IDU_waddr == AW'(i));
    end
  end

  for (genvar g = 1; g < NR_REGS; g++) begin : g_entry
    ysyx_22050550_sb_entry #(
      .CNT_W (CNT_W),
      .DEC_W (DEC_W)
    ) u_entry (
      .clock     (clock),
      .reset     (reset),
      .inc       (inc_vec[g]),
      .dec       (dec_arr[g]),
      .flush     (io_flush),
      .cnt       (cnt_arr[g]),
      .nz        (nz_vec[g]),
      .sat       (sat_vec[g]),
      .underflow (uf_vec[g])
    );
  end

  // Source read ports. Bypass subtracts this cycle's writebacks so a final
  // writeback releases the dependent instruction without waiting a cycle.
  if (WB_BYPASS != 0) begin : g_bypass
    logic [CNT_W-1:0] c1, c2;
    logic [DEC_W-1:0] d1, d2;
    always_comb begin
      c1 = '0; d1 = '0; c2 = '0; d2 = '0;
      if ((io_IDU_raddr1 != '0) && (int'(io_IDU_raddr1) < NR_REGS)) begin
        c1 = cnt_arr[io_IDU_raddr1];
        d1 = dec_arr[io_IDU_raddr1];
      end
      if ((io_IDU_raddr2 != '0) && (int'(io_IDU_raddr2) < NR_REGS)) begin
        c2 = cnt_arr[io_IDU_raddr2];
        d2 = dec_arr[io_IDU_raddr2];
      end
    end
    assign io_IDU_busy1 = io_IDU_valid && (int'(c1) > int'(d1));
    assign io_IDU_busy2 = io_IDU_valid && (int'(c2) > int'(d2));
  end else begin : g_no_bypass
    logic n1, n2;
    always_comb begin
      n1 = 1'b0;
      n2 = 1'b0;
      if ((io_IDU_raddr1 != '0) && (int'(io_IDU_raddr1) < NR_REGS)) begin
        n1 = nz_vec[io_IDU_raddr1];
      end
      if ((io_IDU_raddr2 != '0) && (int'(io_IDU_raddr2) < NR_REGS)) begin
        n2 = nz_vec[io_IDU_raddr2];
      end
    end
    assign io_IDU_busy1 = io_IDU_valid && n1;
    assign io_IDU_busy2 = io_IDU_valid && n2;
  end

  assign io_busy_any = |nz_vec;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      err_q <= 1'b0;
    end else if ((|uf_vec) || issue_illegal) begin
      err_q <= 1'b1;
    end
  end

  assign io_err = err_q;

endmodule

// File: tb/tb_ysyx_22050550_scoreboard_cnt.sv
module tb_ysyx_22050550_scoreboard_cnt;

  logic       clock;
  logic       reset;
  logic       io_IDU_valid;
  logic [4:0] io_IDU_raddr1;
  logic [4:0] io_IDU_raddr2;
  logic [4:0] io_IDU_waddr;
  logic       io_IDU_wen;
  logic       io_IDU_fire;
  logic [1:0] io_WB_wen;
  logic [9:0] io_WB_waddr;
  logic       io_flush;

  logic nb_busy1, nb_busy2, nb_ready, nb_any, nb_err;
  logic bp_busy1, bp_busy2, bp_ready, bp_any, bp_err;

  // Clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  ysyx_22050550_scoreboard_cnt #(.WB_BYPASS(0)) u_dut_nb (
    .clock         (clock),
    .reset         (reset),
    .io_IDU_valid  (io_IDU_valid),
    .io_IDU_raddr1 (io_IDU_raddr1),
    .io_IDU_raddr2 (io_IDU_raddr2),
    .io_IDU_waddr  (io_IDU_waddr),
    .io_IDU_wen    (io_IDU_wen),
    .io_IDU_fire   (io_IDU_fire),
    .io_IDU_busy1  (nb_busy1),
    .io_IDU_busy2  (nb_busy2),
    .io_IDU_ready  (nb_ready),
    .io_WB_wen     (io_WB_wen),
    .io_WB_waddr   (io_WB_waddr),
    .io_flush      (io_flush),
    .io_busy_any   (nb_any),
    .io_err        (nb_err)
  );

  ysyx_22050550_scoreboard_cnt #(.WB_BYPASS(1)) u_dut_bp (
    .clock         (clock),
    .reset         (reset),
    .io_IDU_valid  (io_IDU_valid),
    .io_IDU_raddr1 (io_IDU_raddr1),
    .io_IDU_raddr2 (io_IDU_raddr2),
    .io_IDU_waddr  (io_IDU_waddr),
    .io_IDU_wen    (io_IDU_wen),
    .io_IDU_fire   (io_IDU_fire),
    .io_IDU_busy1  (bp_busy1),
    .io_IDU_busy2  (bp_busy2),
    .io_IDU_ready  (bp_ready),
    .io_WB_wen     (io_WB_wen),
    .io_WB_waddr   (io_WB_waddr),
    .io_flush      (io_flush),
    .io_busy_any   (bp_any),
    .io_err        (bp_err)
  );

  // Scoreboard: {nb busy1,busy2,ready,any,err, bp busy1,busy2,ready,any,err}
  logic [9:0] exp_q[$];
  string      name_q[$];
  int         checks = 0;
  int         errors = 0;

  // Driver: e = {busy1 nb, busy2 nb, ready, busy_any, err, busy1 byp, busy2 byp}
  task automatic drive(input logic v, input logic f, input logic w,
                       input logic [4:0] wa, input logic [4:0] r1, input logic [4:0] r2,
                       input logic [1:0] wbw, input logic [4:0] wb0, input logic [4:0] wb1,
                       input logic fl, input string nm, input logic [6:0] e);
    io_IDU_valid  = v;
    io_IDU_fire   = f;
    io_IDU_wen    = w;
    io_IDU_waddr  = wa;
    io_IDU_raddr1 = r1;
    io_IDU_raddr2 = r2;
    io_WB_wen     = wbw;
    io_WB_waddr   = {wb1, wb0};
    io_flush      = fl;
    exp_q.push_back({e[6], e[5], e[4], e[3], e[2], e[1], e[0], e[4], e[3], e[2]});
    name_q.push_back(nm);
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input string nm, input logic [4:0] r1, input logic [4:0] r2,
                      input logic [6:0] e);
    drive(1'b1, 1'b0, 1'b0, 5'd0, r1, r2, 2'b00, 5'd0, 5'd0, 1'b0, nm, e);
  endtask

  // Monitor: outputs are combinational, compare mid-cycle on the falling edge.
  always @(negedge clock) begin
    if (exp_q.size() > 0) begin
      logic [9:0] got;
      logic [9:0] exp_v;
      string      nm;
      got   = {nb_busy1, nb_busy2, nb_ready, nb_any, nb_err,
               bp_busy1, bp_busy2, bp_ready, bp_any, bp_err};
      exp_v = exp_q.pop_front();
      nm    = name_q.pop_front();
      checks++;
      if (got !== exp_v) begin
        errors++;
        $display("FAIL %s actual=%b required=%b", nm, got, exp_v);
      end
    end
  end

  initial begin
    reset = 1'b1;
    io_IDU_valid = 1'b0; io_IDU_fire = 1'b0; io_IDU_wen = 1'b0;
    io_IDU_waddr = '0; io_IDU_raddr1 = '0; io_IDU_raddr2 = '0;
    io_WB_wen = '0; io_WB_waddr = '0; io_flush = 1'b0;
    @(posedge clock);
    #1;
    drive(1'b0, 1'b0, 1'b0, 5'd0, 5'd5, 5'd0, 2'b00, 5'd0, 5'd0, 1'b0, "reset", 7'b0010000);
    reset = 1'b0;

    // x5 issue then single writeback
    drive(1'b1, 1'b1, 1'b1, 5'd5, 5'd5, 5'd0, 2'b00, 5'd0, 5'd0, 1'b0, "issue_x5", 7'b0010000);
    drive(1'b1, 1'b0, 1'b0, 5'd0, 5'd5, 5'd0, 2'b01, 5'd5, 5'd0, 1'b0, "wb_x5", 7'b1011000);
    idle("x5_clear", 5'd5, 5'd0, 7'b0010000);

    // x7 saturation and dual writeback
    drive(1'b1, 1'b1, 1'b1, 5'd7, 5'd0, 5'd7, 2'b00, 5'd0, 5'd0, 1'b0, "x7_issue1", 7'b0010000);
    drive(1'b1, 1'b1, 1'b1, 5'd7, 5'd0, 5'd7, 2'b00, 5'd0, 5'd0, 1'b0, "x7_issue2", 7'b0111001);
    drive(1'b1, 1'b1, 1'b1, 5'd7, 5'd0, 5'd7, 2'b00, 5'd0, 5'd0, 1'b0, "x7_issue3", 7'b0111001);
    drive(1'b1, 1'b0, 1'b1, 5'd7, 5'd0, 5'd7, 2'b00, 5'd0, 5'd0, 1'b0, "x7_sat_ready", 7'b0101001);
    drive(1'b1, 1'b0, 1'b1, 5'd7, 5'd0, 5'd7, 2'b11, 5'd7, 5'd7, 1'b0, "x7_dual_wb", 7'b0101001);
    drive(1'b1, 1'b0, 1'b1, 5'd7, 5'd0, 5'd7, 2'b00, 5'd0, 5'd0, 1'b0, "x7_cnt1", 7'b0111001);
    drive(1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd7, 2'b01, 5'd7, 5'd0, 1'b0, "x7_drain", 7'b0111000);

    // x3 issue and writeback net out
    drive(1'b1, 1'b1, 1'b1, 5'd3, 5'd3, 5'd0, 2'b00, 5'd0, 5'd0, 1'b0, "x3_issue", 7'b0010000);
    drive(1'b1, 1'b1, 1'b1, 5'd3, 5'd3, 5'd0, 2'b10, 5'd0, 5'd3, 1'b0, "x3_net", 7'b1011000);
    idle("x3_still_busy", 5'd3, 5'd0, 7'b1011010);

    // Build x1=2, x9=1, then flush with a competing issue to x4
    drive(1'b1, 1'b1, 1'b1, 5'd1, 5'd0, 5'd0, 2'b00, 5'd0, 5'd0, 1'b0, "x1_issue1", 7'b0011000);
    drive(1'b1, 1'b1, 1'b1, 5'd1, 5'd0, 5'd0, 2'b00, 5'd0, 5'd0, 1'b0, "x1_issue2", 7'b0011000);
    drive(1'b1, 1'b1, 1'b1, 5'd9, 5'd0, 5'd0, 2'b00, 5'd0, 5'd0, 1'b0, "x9_issue", 7'b0011000);
    drive(1'b1, 1'b1, 1'b1, 5'd4, 5'd4, 5'd1, 2'b00, 5'd0, 5'd0, 1'b1, "flush_cycle", 7'b0111001);
    idle("after_flush", 5'd4, 5'd1, 7'b0010000);
    idle("after_flush_x9", 5'd9, 5'd3, 7'b0010000);

    // Underflow on x6, sticky through flush
    drive(1'b0, 1'b0, 1'b0, 5'd0, 5'd6, 5'd0, 2'b01, 5'd6, 5'd0, 1'b0, "wb_x6_uf", 7'b0010000);
    idle("err_set", 5'd6, 5'd0, 7'b0010100);
    drive(1'b1, 1'b0, 1'b0, 5'd0, 5'd6, 5'd0, 2'b00, 5'd0, 5'd0, 1'b1, "err_flush", 7'b0010100);
    idle("err_after_flush", 5'd6, 5'd0, 7'b0010100);

    // Register 0 is never tracked
    drive(1'b1, 1'b1, 1'b1, 5'd0, 5'd0, 5'd0, 2'b00, 5'd0, 5'd0, 1'b0, "x0_issue", 7'b0010100);
    idle("x0_no_track", 5'd0, 5'd0, 7'b0010100);

    // Mid-run reset clears err and all state asynchronously
    drive(1'b1, 1'b1, 1'b1, 5'd2, 5'd0, 5'd0, 2'b00, 5'd0, 5'd0, 1'b0, "x2_issue", 7'b0010100);
    reset = 1'b1;
    idle("reset_clears", 5'd2, 5'd0, 7'b0010000);
    reset = 1'b0;
    idle("post_reset", 5'd2, 5'd0, 7'b0010000);

    @(negedge clock);
    @(negedge clock);
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain actual=%0d required=0 pending expectations", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
